// File: rtl/mem_split_pkg.sv
// Shared encodings for the memory-access splitter: FSM states, access-size
// codes and the byte-count helper.
package mem_split_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_LO = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_SEND_HI = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_WORD  = 2'b01;
  localparam logic [1:0] SZ_DWORD = 2'b10;

  // The reserved size code behaves like a full 4-byte access.
  function automatic logic [2:0] nbytes_from_size(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE:  n = 3'd1;
      SZ_WORD:  n = 3'd2;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_access_splitter_byte_lane_shifter.sv
// Combinational byte-lane shifter: moves a 64-bit vector by 8*offset bits,
// left (store alignment) or right (load merge), truncated to OUT_W bits.
module byte_lane_shifter #(
  parameter bit SHIFT_RIGHT = 1'b0,
  parameter int OUT_W       = 64
) (
  input  logic [63:0]      i_data,
  input  logic [1:0]       i_off,
  output logic [OUT_W-1:0] o_data
);

  logic [4:0] w_amt;

  assign w_amt  = {i_off, 3'b000};
  assign o_data = OUT_W'(SHIFT_RIGHT ? (i_data >> w_amt) : (i_data << w_amt));

endmodule

// File: rtl/mem_access_splitter.sv
// Splits unaligned loads/stores into one or two aligned 32-bit word requests
// and merges read data. Optional split counter under `MEM_SPLIT_CNT_EN.
//
// state   | meaning
// IDLE    | ready for a new address-generator transaction
// SEND_LO | low word request presented, waiting for mem_req_ready
// WAIT_LO | waiting for the low word response
// SEND_HI | high word request presented (split accesses only)
// WAIT_HI | waiting for the high word response
// DONE    | result presented to writeback until out_ready
module mem_access_splitter
  import mem_split_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ag_valid,
  output logic        ag_ready,
  input  logic [31:0] ag_addr,
  input  logic [1:0]  ag_size,
  input  logic        ag_wr,
  input  logic [31:0] ag_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
`ifdef MEM_SPLIT_CNT_EN
  ,
  output logic [15:0] split_cnt
`endif
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [2:0]  r_nbytes;
  logic        r_wr;
  logic [31:0] r_wdata;
  logic        r_split;
  logic [31:0] r_rsp_lo;
  logic [31:0] r_rsp_hi;

  logic [2:0]  w_ag_nbytes;
  logic [3:0]  w_ag_end;
  logic        w_ag_split;
  logic        w_accept;
  logic [1:0]  w_off;
  logic [7:0]  w_lo_mask;
  logic [7:0]  w_mask8;
  logic [31:0] w_data_mask;
  logic [63:0] w_wide;
  logic [31:0] w_merged;

  assign w_ag_nbytes = nbytes_from_size(ag_size);
  assign w_ag_end    = {2'b00, ag_addr[1:0]} + {1'b0, w_ag_nbytes};
  assign w_ag_split  = (w_ag_end > 4'd4);
  assign w_accept    = (r_state == ST_IDLE) && ag_valid;

  assign w_off = r_addr[1:0];

  always_comb begin
    w_lo_mask   = 8'h0F;
    w_data_mask = 32'hFFFF_FFFF;
    case (r_nbytes)
      3'd1: begin
        w_lo_mask   = 8'h01;
        w_data_mask = 32'h0000_00FF;
      end
      3'd2: begin
        w_lo_mask   = 8'h03;
        w_data_mask = 32'h0000_FFFF;
      end
      default: begin
        w_lo_mask   = 8'h0F;
        w_data_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign w_mask8 = w_lo_mask << w_off;

  byte_lane_shifter #(.SHIFT_RIGHT(1'b0), .OUT_W(64)) u_wr_align (
    .i_data (ag_wdata_pad(r_wdata)),
    .i_off  (w_off),
    .o_data (w_wide)
  );

  byte_lane_shifter #(.SHIFT_RIGHT(1'b1), .OUT_W(32)) u_rd_merge (
    .i_data ({r_rsp_hi, r_rsp_lo}),
    .i_off  (w_off),
    .o_data (w_merged)
  );

  function automatic logic [63:0] ag_wdata_pad(input logic [31:0] d);
    return {32'h0, d};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    ag_ready      = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = 32'h0;
    mem_be        = 4'h0;
    mem_wr        = 1'b0;
    mem_wdata     = 32'h0;
    out_valid     = 1'b0;
    out_data      = 32'h0;
    case (r_state)
      ST_IDLE: begin
        ag_ready = !rst;
        if (ag_valid) begin
          w_state_nxt = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        mem_req_valid = 1'b1;
        mem_addr      = {r_addr[31:2], 2'b00};
        mem_be        = w_mask8[3:0];
        mem_wr        = r_wr;
        mem_wdata     = w_wide[31:0];
        if (mem_req_ready) begin
          w_state_nxt = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (mem_rsp_valid) begin
          w_state_nxt = r_split ? ST_SEND_HI : ST_DONE;
        end
      end
      ST_SEND_HI: begin
        // Next word address wraps naturally at the top of the address space.
        mem_req_valid = 1'b1;
        mem_addr      = {r_addr[31:2] + 30'd1, 2'b00};
        mem_be        = w_mask8[7:4];
        mem_wr        = r_wr;
        mem_wdata     = w_wide[63:32];
        if (mem_req_ready) begin
          w_state_nxt = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (mem_rsp_valid) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        out_data  = r_wr ? 32'h0 : (w_merged & w_data_mask);
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= 32'h0;
      r_nbytes <= 3'd0;
      r_wr     <= 1'b0;
      r_wdata  <= 32'h0;
      r_split  <= 1'b0;
      r_rsp_lo <= 32'h0;
      r_rsp_hi <= 32'h0;
    end else begin
      if (w_accept) begin
        r_addr   <= ag_addr;
        r_nbytes <= w_ag_nbytes;
        r_wr     <= ag_wr;
        r_wdata  <= ag_wdata;
        r_split  <= w_ag_split;
        r_rsp_lo <= 32'h0;
        r_rsp_hi <= 32'h0;
      end
      if ((r_state == ST_WAIT_LO) && mem_rsp_valid) begin
        r_rsp_lo <= mem_rsp_data;
      end
      if ((r_state == ST_WAIT_HI) && mem_rsp_valid) begin
        r_rsp_hi <= mem_rsp_data;
      end
    end
  end

`ifdef MEM_SPLIT_CNT_EN
  logic [15:0] r_split_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_split_cnt <= 16'h0;
    end else if (w_accept && w_ag_split) begin
      r_split_cnt <= r_split_cnt + 16'd1;
    end
  end

  assign split_cnt = r_split_cnt;
`endif

endmodule

// File: tb/tb_mem_access_splitter.sv
// Directed self-checking bench for mem_access_splitter; build with
// +define+MEM_SPLIT_CNT_EN to also check the split counter.
module tb_mem_access_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ag_valid;
  logic        ag_ready;
  logic [31:0] ag_addr;
  logic [1:0]  ag_size;
  logic        ag_wr;
  logic [31:0] ag_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef MEM_SPLIT_CNT_EN
  logic [15:0] split_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_splitter dut (
    .clk           (clk),
    .rst           (rst),
    .ag_valid      (ag_valid),
    .ag_ready      (ag_ready),
    .ag_addr       (ag_addr),
    .ag_size       (ag_size),
    .ag_wr         (ag_wr),
    .ag_wdata      (ag_wdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wr        (mem_wr),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
`ifdef MEM_SPLIT_CNT_EN
    ,
    .split_cnt     (split_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one transaction for a single cycle; returns at the T+1 negedge.
  task automatic accept(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic wr, input logic [31:0] wdata);
    @(negedge clk);
    chk({tag, ".ag_ready_idle"}, {31'h0, ag_ready}, 32'h1);
    ag_valid = 1'b1;
    ag_addr  = addr;
    ag_size  = size;
    ag_wr    = wr;
    ag_wdata = wdata;
    @(negedge clk);
    ag_valid = 1'b0;
    chk({tag, ".ag_ready_busy"}, {31'h0, ag_ready}, 32'h0);
  endtask

  // Checks the pending request, accepts it, then returns a zero-wait response.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic exp_wr, input logic [31:0] exp_wdata, input logic [31:0] rsp);
    chk({tag, ".req_valid"}, {31'h0, mem_req_valid}, 32'h1);
    chk({tag, ".addr"}, mem_addr, exp_addr);
    chk({tag, ".be"}, {28'h0, mem_be}, {28'h0, exp_be});
    chk({tag, ".wr"}, {31'h0, mem_wr}, {31'h0, exp_wr});
    chk({tag, ".wdata"}, mem_wdata, exp_wdata);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk({tag, ".req_dropped"}, {31'h0, mem_req_valid}, 32'h0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rsp;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
  endtask

  task automatic finish_done(input string tag, input logic [31:0] exp_data);
    chk({tag, ".out_valid"}, {31'h0, out_valid}, 32'h1);
    chk({tag, ".out_data"}, out_data, exp_data);
    @(negedge clk);
    chk({tag, ".out_cleared"}, {31'h0, out_valid}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    ag_valid      = 1'b0;
    ag_addr       = 32'h0;
    ag_size       = 2'b00;
    ag_wr         = 1'b0;
    ag_wdata      = 32'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    out_ready     = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst.ag_ready", {31'h0, ag_ready}, 32'h0);
    chk("rst.req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst.mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst.out_data", out_data, 32'h0);
`ifdef MEM_SPLIT_CNT_EN
    chk("rst.split_cnt", {16'h0, split_cnt}, 32'h0);
`endif
    rst = 1'b0;
    #1;
    chk("rst.ag_ready_after", {31'h0, ag_ready}, 32'h1);

    // Aligned word load: one request, result at T+3.
    accept("ld_w", 32'h0000_1000, 2'b10, 1'b0, 32'h0);
    serve("ld_w", 32'h0000_1000, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF);
    finish_done("ld_w", 32'hDEAD_BEEF);

    // Word load straddling a word boundary.
    accept("ld_split", 32'h0000_1003, 2'b10, 1'b0, 32'h0);
    serve("ld_split.lo", 32'h0000_1000, 4'b1000, 1'b0, 32'h0, 32'h4433_2211);
    serve("ld_split.hi", 32'h0000_1004, 4'b0111, 1'b0, 32'h0, 32'h8877_6655);
    finish_done("ld_split", 32'h7766_5544);
`ifdef MEM_SPLIT_CNT_EN
    chk("ld_split.split_cnt", {16'h0, split_cnt}, 32'h1);
`endif

    // Byte load at offset 1, zero-extended.
    accept("ld_b", 32'h0000_3001, 2'b00, 1'b0, 32'h0);
    serve("ld_b", 32'h0000_3000, 4'b0010, 1'b0, 32'h0, 32'hA1B2_C3D4);
    finish_done("ld_b", 32'h0000_00C3);

    // Reserved size code acts as 4 bytes.
    accept("ld_rsv", 32'h0000_4000, 2'b11, 1'b0, 32'h0);
    serve("ld_rsv", 32'h0000_4000, 4'b1111, 1'b0, 32'h0, 32'h0102_0304);
    finish_done("ld_rsv", 32'h0102_0304);

    // Halfword store in the upper lanes; result is zero for stores.
    accept("st_h", 32'h0000_2002, 2'b01, 1'b1, 32'h0000_ABCD);
    serve("st_h", 32'h0000_2000, 4'b1100, 1'b1, 32'hABCD_0000, 32'hFFFF_FFFF);
    finish_done("st_h", 32'h0);

    // Split store wrapping past the top of the address space.
    accept("st_wrap", 32'hFFFF_FFFE, 2'b10, 1'b1, 32'h1122_3344);
    serve("st_wrap.lo", 32'hFFFF_FFFC, 4'b1100, 1'b1, 32'h3344_0000, 32'h0);
    serve("st_wrap.hi", 32'h0000_0000, 4'b0011, 1'b1, 32'h0000_1122, 32'h0);
    finish_done("st_wrap", 32'h0);
`ifdef MEM_SPLIT_CNT_EN
    chk("st_wrap.split_cnt", {16'h0, split_cnt}, 32'h2);
`endif

    // Backpressure on both sides while a competing ag transaction is offered.
    accept("bp", 32'h0000_5000, 2'b01, 1'b0, 32'h0);
    ag_valid = 1'b1;
    ag_addr  = 32'h9999_0000;
    ag_size  = 2'b10;
    for (int i = 0; i < 3; i++) begin
      chk("bp.stall_req_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("bp.stall_addr", mem_addr, 32'h0000_5000);
      chk("bp.stall_be", {28'h0, mem_be}, 32'h3);
      chk("bp.stall_ag_ready", {31'h0, ag_ready}, 32'h0);
      @(negedge clk);
    end
    serve("bp", 32'h0000_5000, 4'b0011, 1'b0, 32'h0, 32'h1234_5678);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp.hold_out_valid", {31'h0, out_valid}, 32'h1);
      chk("bp.hold_out_data", out_data, 32'h0000_5678);
      chk("bp.hold_ag_ready", {31'h0, ag_ready}, 32'h0);
      @(negedge clk);
    end
    ag_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp.release_out_valid", {31'h0, out_valid}, 32'h1);
    @(negedge clk);
    chk("bp.idle_out_valid", {31'h0, out_valid}, 32'h0);
    chk("bp.idle_ag_ready", {31'h0, ag_ready}, 32'h1);
    @(negedge clk);
    chk("bp.no_extra_req", {31'h0, mem_req_valid}, 32'h0);

    // Reset while waiting for the high-word response; late response ignored.
    accept("rst_mid", 32'h0000_6002, 2'b10, 1'b0, 32'h0);
    serve("rst_mid.lo", 32'h0000_6000, 4'b1100, 1'b0, 32'h0, 32'hAAAA_AAAA);
    chk("rst_mid.hi_addr", mem_addr, 32'h0000_6004);
    chk("rst_mid.hi_be", {28'h0, mem_be}, 32'h3);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
`ifdef MEM_SPLIT_CNT_EN
    chk("rst_mid.split_cnt", {16'h0, split_cnt}, 32'h3);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.ag_ready", {31'h0, ag_ready}, 32'h0);
    chk("rst_mid.req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_mid.mem_addr", mem_addr, 32'h0);
    chk("rst_mid.mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_mid.out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid.out_data", out_data, 32'h0);
`ifdef MEM_SPLIT_CNT_EN
    chk("rst_mid.split_cnt_clr", {16'h0, split_cnt}, 32'h0);
`endif
    rst           = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD0_BAD0;
    #1;
    chk("rst_mid.ag_ready_after", {31'h0, ag_ready}, 32'h1);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    chk("rst_mid.late_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid.late_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_mid.late_ag_ready", {31'h0, ag_ready}, 32'h1);

    // Normal halfword load after the reset.
    accept("post_rst", 32'h0000_8001, 2'b01, 1'b0, 32'h0);
    serve("post_rst", 32'h0000_8000, 4'b0110, 1'b0, 32'h0, 32'h00CA_FE00);
    finish_done("post_rst", 32'h0000_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
